front_instr_fifo: RTL
=====================

FRONT_INSTR_FIFO -- requirements
Module: front_instr_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 3, log2 of word slots; DEPTH = 2**DEPTH_LOG2 words (16 bytes at default).
REQ-002 wb_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-003 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 flush  in  1  discard contents and restart the byte stream at requested_cs:requested_ip.
REQ-005 load_cs_ip  in  1  treated identically to flush.
REQ-006 requested_cs  in  16  new code segment, sampled on flush/load_cs_ip.
REQ-007 requested_ip  in  16  new instruction pointer, sampled on flush/load_cs_ip.
REQ-008 fifo_dat_i  in  16  fetched word; bits [7:0] are the lower-addressed byte.
REQ-009 wr_fifo  in  1  one-cycle write strobe for fifo_dat_i.
REQ-010 fifo_full  out  1  back-pressure to the prefetch stage.
REQ-011 rd_dat  out  16  next two stream bytes; [7:0] is the byte at out_cs:out_ip.
REQ-012 avail  out  2  valid bytes on rd_dat: 0, 1 or 2 (clipped at 2).
REQ-013 consume  in  2  bytes popped this cycle (0..2).
REQ-014 out_cs  out  16  segment of the stream.
REQ-015 out_ip  out  16  IP of rd_dat[7:0].
REQ-016 err_ovf  out  1  sticky: a write arrived with no free slot.

Function
REQ-017 Storage: DEPTH x 16-bit word array; wr_wptr is a (DEPTH_LOG2+1)-bit word pointer; rd_bptr is a (DEPTH_LOG2+2)-bit byte pointer; the MSB of each is a wrap bit.
REQ-018 words_used = wr_wptr - rd_bptr[DEPTH_LOG2+1:1], modulo 2**(DEPTH_LOG2+1); a partly consumed word still occupies its slot.
REQ-019 fifo_full = (words_used >= DEPTH-1), combinational from registers; the one slot of margin absorbs the producer's registered wr_fifo that follows a stall decision.
REQ-020 Byte count cnt ranges 0..2*DEPTH; avail = min(cnt, 2).
REQ-021 Write (wr_fifo=1, no flush, words_used < DEPTH): store at wr_wptr, increment wr_wptr, add 2 to cnt, or add 1 if it is the first word after an odd-IP restart.
REQ-022 Write with words_used == DEPTH: drop the data, leave pointers unchanged, set err_ovf.
REQ-023 Written data becomes visible on rd_dat/avail one cycle after the write; there is no same-cycle bypass.
REQ-024 Pop: n = min(consume, avail); rd_bptr += n, cnt -= n, out_ip += n (16-bit wrap, out_cs unchanged).
REQ-025 A simultaneous write and pop both take effect; cnt changes by the write amount minus n.
REQ-026 rd_dat[7:0] = byte at rd_bptr; rd_dat[15:8] = byte at rd_bptr+1, which may straddle a word and wrap the array; bytes beyond avail are driven 0.
REQ-027 Flush or load_cs_ip (registered): wr_wptr=0, rd_bptr = {0, requested_ip[0]}, cnt=0, out_cs=requested_cs, out_ip=requested_ip, odd_first=requested_ip[0], err_ovf=0.
REQ-028 Any write or pop in the flush cycle is discarded.
REQ-029 odd_first clears on the first accepted write after a restart; that write's low byte is skipped because rd_bptr already points at byte 1.
REQ-030 fifo_full is deasserted in the cycle after a flush.

Reset
REQ-031 On wb_rst_i assertion, asynchronously: wr_wptr=0, rd_bptr=0, cnt=0, odd_first=0, err_ovf=0, out_cs=16'hF000, out_ip=16'hFFF0.
REQ-032 Reset outputs: fifo_full=0, avail=0, rd_dat=0; array contents need not be reset.
REQ-033 Reset asserted mid-operation overrides flush, writes and pops; no write is accepted while reset is high.

Verification
REQ-034 Reset release, no writes -> avail=0, out_cs:out_ip=F000:FFF0, fifo_full=0.
REQ-035 Write 16'hB8EA, then 16'h1234; consume=2 each cycle -> rd_dat=B8EA (ip FFF0), then 1234 (ip FFF2), then avail=0, out_ip=FFF4.
REQ-036 Flush to 0000:0101, write 16'hAABB -> avail=1, rd_dat=00AA, out_ip=0101; consume=1 -> out_ip=0102, avail=0.
REQ-037 Write DEPTH-1 words with no pops -> fifo_full=1 after the 7th write (default DEPTH); an 8th write is accepted with err_ovf=0; a 9th write sets err_ovf=1.
REQ-038 Mixed consume=1 and consume=2 with writes every cycle across array wrap -> byte order is preserved, straddling bytes are correct, and out_ip advances by exactly the bytes popped.
REQ-039 flush asserted in the same cycle as wr_fifo and consume=2 -> the write and pop are discarded, cnt=0, and out_ip=requested_ip next cycle.

Source files
------------

// File: rtl/front_instr_fifo.sv
// Byte-stream instruction FIFO between the word-wide prefetch stage and the decoder.
// Words go in 16 bits at a time; the decoder sees the next two bytes and pops 0..2 per cycle.
`timescale 1ns/1ps
module front_instr_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        flush,
  input  logic        load_cs_ip,
  input  logic [15:0] requested_cs,
  input  logic [15:0] requested_ip,
  input  logic [15:0] fifo_dat_i,
  input  logic        wr_fifo,
  output logic        fifo_full,
  output logic [15:0] rd_dat,
  output logic [1:0]  avail,
  input  logic [1:0]  consume,
  output logic [15:0] out_cs,
  output logic [15:0] out_ip,
  output logic        err_ovf
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int WP_W  = DEPTH_LOG2 + 1;
  localparam int BP_W  = DEPTH_LOG2 + 2;
  localparam int CNT_W = DEPTH_LOG2 + 2;

  logic [15:0]       mem_q [DEPTH];
  logic [WP_W-1:0]   wr_wptr_q, wr_wptr_d;
  logic [BP_W-1:0]   rd_bptr_q, rd_bptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              odd_first_q, odd_first_d;
  logic              err_ovf_q, err_ovf_d;
  logic [15:0]       out_cs_q, out_cs_d;
  logic [15:0]       out_ip_q, out_ip_d;

  logic [WP_W-1:0]       words_used;
  logic                  restart;
  logic                  wr_ok;
  logic                  mem_we;
  logic [1:0]            pop_n;
  logic [1:0]            wr_amt;
  logic [DEPTH_LOG2-1:0] idx0, idx1;
  logic [15:0]           word0, word1;
  logic [7:0]            byte0, byte1;

  function automatic logic [1:0] sat2(input logic [CNT_W-1:0] v);
    return (v >= CNT_W'(2)) ? 2'd2 : v[1:0];
  endfunction

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? b : a;
  endfunction

  assign words_used = wr_wptr_q - rd_bptr_q[BP_W-1:1];
  assign fifo_full  = (words_used >= WP_W'(DEPTH - 1));
  assign avail      = sat2(cnt_q);
  assign restart    = flush | load_cs_ip;
  assign wr_ok      = wr_fifo & ~restart & (words_used != WP_W'(DEPTH));
  assign mem_we     = wr_ok & ~wb_rst_i;
  assign pop_n      = min2(consume, avail);
  assign wr_amt     = odd_first_q ? 2'd1 : 2'd2;

  // Second byte lives in the next slot when the read pointer sits on an odd byte.
  assign idx0  = rd_bptr_q[DEPTH_LOG2:1];
  assign idx1  = rd_bptr_q[0] ? idx0 + DEPTH_LOG2'(1) : idx0;
  assign word0 = mem_q[idx0];
  assign word1 = mem_q[idx1];
  assign byte0 = rd_bptr_q[0] ? word0[15:8] : word0[7:0];
  assign byte1 = rd_bptr_q[0] ? word1[7:0]  : word0[15:8];

  assign rd_dat  = {(avail == 2'd2) ? byte1 : 8'h00, (avail != 2'd0) ? byte0 : 8'h00};
  assign out_cs  = out_cs_q;
  assign out_ip  = out_ip_q;
  assign err_ovf = err_ovf_q;

  always_comb begin
    wr_wptr_d   = wr_wptr_q;
    rd_bptr_d   = rd_bptr_q;
    cnt_d       = cnt_q;
    odd_first_d = odd_first_q;
    err_ovf_d   = err_ovf_q;
    out_cs_d    = out_cs_q;
    out_ip_d    = out_ip_q;
    if (restart) begin
      wr_wptr_d   = '0;
      rd_bptr_d   = {{(BP_W-1){1'b0}}, requested_ip[0]};
      cnt_d       = '0;
      odd_first_d = requested_ip[0];
      err_ovf_d   = 1'b0;
      out_cs_d    = requested_cs;
      out_ip_d    = requested_ip;
    end else begin
      rd_bptr_d = rd_bptr_q + BP_W'(pop_n);
      out_ip_d  = out_ip_q + 16'(pop_n);
      if (wr_ok) begin
        wr_wptr_d   = wr_wptr_q + WP_W'(1);
        cnt_d       = cnt_q + CNT_W'(wr_amt) - CNT_W'(pop_n);
        odd_first_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(pop_n);
        if (wr_fifo) err_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_wptr_q   <= '0;
      rd_bptr_q   <= '0;
      cnt_q       <= '0;
      odd_first_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      out_cs_q    <= 16'hF000;
      out_ip_q    <= 16'hFFF0;
    end else begin
      wr_wptr_q   <= wr_wptr_d;
      rd_bptr_q   <= rd_bptr_d;
      cnt_q       <= cnt_d;
      odd_first_q <= odd_first_d;
      err_ovf_q   <= err_ovf_d;
      out_cs_q    <= out_cs_d;
      out_ip_q    <= out_ip_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (mem_we) mem_q[wr_wptr_q[DEPTH_LOG2-1:0]] <= fifo_dat_i;
  end

endmodule
